// File: rtl/peripheral_wb_master_bb.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_wb_master_bb
// Purpose  : Command-driven Wishbone B4 burst master. A command (address, byte
//            select, 1..16 beats, read/write) is accepted in IDLE. It is then
//            executed as a linear incrementing burst with retry, error and
//            timeout handling, and reported by a one-cycle done or err pulse.
// Ports    : wb_clk, wb_rst_n        - clock, async active-low reset
//            cmd_*                   - command handshake and fields
//            wdat/wdat_valid/_ready  - write-data stream (one word per beat)
//            rdat/rdat_valid         - read-data stream (no backpressure)
//            done, err               - completion pulses
//            wb_*_o / wb_*_i         - Wishbone master signals
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_wb_master_bb #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [3:0]      cmd_len,
  input  logic [DW-1:0]   wdat,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  output logic [DW-1:0]   rdat,
  output logic            rdat_valid,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  // Counter only has to hold 0..TIMEOUT-1.
  localparam int            c_tmo_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [AW-1:0] c_adr_step = AW'(DW / 8);
  localparam logic [2:0]    c_cti_classic = 3'b000;
  localparam logic [2:0]    c_cti_incr    = 3'b010;
  localparam logic [2:0]    c_cti_end     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_cmd_ready;
  logic                 r_we;
  logic [AW-1:0]        r_adr;
  logic [DW/8-1:0]      r_sel;
  logic [DW-1:0]        r_dat;
  logic                 r_cyc;
  logic                 r_stb;
  logic [2:0]           r_cti;
  logic [3:0]           r_left;      // beats remaining after the current one
  logic [c_tmo_w-1:0]   r_tmo;
  logic [DW-1:0]        r_rdat;
  logic                 r_rdat_valid;
  logic                 r_done;
  logic                 r_err;

  logic w_strobe;
  logic w_ack;
  logic w_err;
  logic w_silent;
  logic w_abort;
  logic w_wacc;

  // Slave responses only count during a strobe; err beats ack beats rty.
  assign w_strobe = r_cyc & r_stb;
  assign w_err    = w_strobe & wb_err_i;
  assign w_ack    = w_strobe & wb_ack_i & ~wb_err_i;
  assign w_silent = w_strobe & ~wb_ack_i & ~wb_err_i & ~wb_rty_i;
  // A silent strobe with the counter already at TIMEOUT-1 aborts like err.
  assign w_abort  = w_err | (w_silent & (r_tmo == c_tmo_last));

  // For writes the strobe doubles as the "beat pending" flag.
  assign wdat_ready = (r_state == BUS) & r_we & ~r_stb;
  assign w_wacc     = wdat_ready & wdat_valid;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_cti        <= c_cti_classic;
      r_left       <= 4'd0;
      r_tmo        <= '0;
      r_rdat       <= '0;
      r_rdat_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rdat_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_state     <= BUS;
            r_we        <= cmd_we;
            r_adr       <= cmd_adr;
            r_sel       <= cmd_sel;
            r_left      <= cmd_len;
            r_cti       <= (cmd_len == 4'd0) ? c_cti_classic : c_cti_incr;
            r_cyc       <= 1'b1;
            r_stb       <= ~cmd_we;   // reads strobe at once, writes wait for data
            r_tmo       <= '0;
          end
        end
        BUS: begin
          if (w_wacc) begin
            r_dat <= wdat;
            r_stb <= 1'b1;
          end
          if (w_abort) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_tmo   <= '0;
            r_state <= RESP;
          end else if (w_ack) begin
            r_adr <= r_adr + c_adr_step;
            r_tmo <= '0;
            if (!r_we) begin
              r_rdat       <= wb_dat_i;
              r_rdat_valid <= 1'b1;
            end
            if (r_left == 4'd0) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_left <= r_left - 4'd1;
              r_cti  <= (r_left == 4'd1) ? c_cti_end : c_cti_incr;
              if (r_we) begin
                r_stb <= 1'b0;
              end
            end
          end else if (w_silent) begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end else begin
            // rty, or no strobe (write wait state): restart the count
            r_tmo <= '0;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rdat       = r_rdat;
  assign rdat_valid = r_rdat_valid;
  assign done       = r_done;
  assign err        = r_err;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_sel_o   = r_sel;
  assign wb_we_o    = r_we;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_cti_o   = r_cti;
  assign wb_bte_o   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_wb_master_bb.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_wb_master_bb
// Purpose  : Self-checking bench for peripheral_wb_master_bb. It acts as the
//            command source, write-data source and Wishbone slave. Every
//            cycle it compares the DUT outputs with a beat-count reference
//            model of the command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_wb_master_bb;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 12;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [3:0]    cmd_sel = '0;
  logic [3:0]    cmd_len = '0;
  logic [DW-1:0] wdat = '0;
  logic          wdat_valid = 1'b0;
  logic          wdat_ready;
  logic [DW-1:0] rdat;
  logic          rdat_valid;
  logic          done;
  logic          err;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic          wb_rty_i = 1'b0;

  peripheral_wb_master_bb #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wdat(wdat), .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
    .rdat(rdat), .rdat_valid(rdat_valid), .done(done), .err(err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: ph 0 = accepting, 1 = bus transfer, 2 = completion pulse
  int            ph = 0;
  logic          m_we = 1'b0;
  logic [31:0]   m_base = '0;
  logic [3:0]    m_sel = '0;
  int            m_n = 1;
  int            k = 0;        // beats acknowledged
  int            wi = 0;       // write words handed over
  int            silent = 0;   // consecutive strobe cycles with no response
  int            scnt = 0;     // strobe cycles spent on the current beat
  int            gap = 0;
  logic          m_done = 1'b0;
  logic          m_err = 1'b0;
  logic          m_rv = 1'b0;
  logic [31:0]   m_rdat = '0;
  logic [31:0]   words [16];

  // Pending command and slave behaviour
  logic          want_cmd = 1'b0;
  logic          issued = 1'b0;
  logic          c_we = 1'b0;
  logic [31:0]   c_adr = '0;
  logic [3:0]    c_len = '0;
  logic [3:0]    c_sel = '0;
  int            smode = 0;    // 0 random, 1 ack 2nd strobe, 2 err on beat eb, 3 rty then ack, 4 silent
  int            wmode = 0;    // 0 random valid, 1 always valid with 2-cycle gap before beat 3
  int            errbeat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"},   32'(wb_cyc_o),   32'd0);
    check({tag, "_stb"},   32'(wb_stb_o),   32'd0);
    check({tag, "_rdy"},   32'(cmd_ready),  32'd0);
    check({tag, "_wrdy"},  32'(wdat_ready), 32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_rv"},    32'(rdat_valid), 32'd0);
    check({tag, "_rdat"},  rdat,            32'd0);
    check({tag, "_adr"},   wb_adr_o,        32'd0);
    check({tag, "_dat"},   wb_dat_o,        32'd0);
    check({tag, "_cti"},   32'(wb_cti_o),   32'd0);
    check({tag, "_we"},    32'(wb_we_o),    32'd0);
    check({tag, "_sel"},   32'(wb_sel_o),   32'd0);
  endtask

  // One clock: check outputs, drive the next inputs, advance the model.
  task automatic cycle();
    logic exp_stb, exp_wr, a, e, y, nd, ne, nrv;
    int   r;
    @(negedge wb_clk);
    exp_stb = (ph == 1) && (m_we ? (wi > k) : 1'b1);
    exp_wr  = (ph == 1) && m_we && (wi == k);
    check("cmd_ready",  32'(cmd_ready),  32'(ph == 0));
    check("cyc",        32'(wb_cyc_o),   32'(ph == 1));
    check("stb",        32'(wb_stb_o),   32'(exp_stb));
    check("wdat_ready", 32'(wdat_ready), 32'(exp_wr));
    check("done",       32'(done),       32'(m_done));
    check("err",        32'(err),        32'(m_err));
    check("rdat_valid", 32'(rdat_valid), 32'(m_rv));
    check("bte",        32'(wb_bte_o),   32'd0);
    if (m_rv) check("rdat", rdat, m_rdat);
    if (exp_stb) begin
      check("adr", wb_adr_o, m_base + 32'(k) * 32'd4);
      check("cti", 32'(wb_cti_o), (m_n == 1) ? 32'd0 : ((k == m_n - 1) ? 32'd7 : 32'd2));
      check("we",  32'(wb_we_o),  32'(m_we));
      check("sel", 32'(wb_sel_o), 32'(m_sel));
      if (m_we) check("wdat_o", wb_dat_o, words[k]);
    end

    // command port (noise while not accepting)
    if (ph == 0 && want_cmd && (smode != 0 || ($urandom % 4) != 0)) begin
      cmd_valid = 1'b1; cmd_we = c_we; cmd_adr = c_adr; cmd_len = c_len; cmd_sel = c_sel;
    end else begin
      cmd_valid = (ph != 0) ? 1'($urandom) : 1'b0;
      cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_len = 4'($urandom); cmd_sel = 4'($urandom);
    end

    // write-data stream
    wdat = (wi < 16) ? words[wi] : 32'd0;
    if (wmode == 1) begin
      wdat_valid = !(wi == 2 && gap < 2);
      if (exp_wr && wi == 2 && gap < 2) gap++;
    end else begin
      wdat_valid = 1'($urandom);
    end

    // slave
    wb_dat_i = $urandom;
    a = 1'b0; e = 1'b0; y = 1'b0;
    if (exp_stb) begin
      case (smode)
        0: begin
          r = int'($urandom % 100);
          if (r < 3)       begin e = 1'b1; a = 1'($urandom); y = 1'($urandom); end
          else if (r < 50) begin a = 1'b1; y = 1'($urandom); end
          else if (r < 60) y = 1'b1;
        end
        1: a = (scnt == 1);
        2: if (k == errbeat) e = 1'b1; else a = 1'b1;
        3: if (scnt == 0) y = 1'b1; else a = 1'b1;
        default: ;
      endcase
    end else begin
      a = (($urandom % 3) == 0); e = (($urandom % 5) == 0); y = (($urandom % 4) == 0);
    end
    wb_ack_i = a; wb_err_i = e; wb_rty_i = y;

    // model the coming edge
    nd = 1'b0; ne = 1'b0; nrv = 1'b0;
    case (ph)
      0: if (cmd_valid) begin
        ph = 1; m_we = cmd_we; m_base = cmd_adr; m_n = int'(cmd_len) + 1; m_sel = cmd_sel;
        k = 0; wi = 0; silent = 0; scnt = 0; issued = 1'b1; want_cmd = 1'b0;
      end
      1: begin
        if (exp_wr && wdat_valid) wi++;
        if (exp_stb) begin
          if (e) begin
            ph = 2; ne = 1'b1;
          end else if (a) begin
            if (!m_we) begin nrv = 1'b1; m_rdat = wb_dat_i; end
            k++; silent = 0; scnt = 0;
            if (k == m_n) begin ph = 2; nd = 1'b1; end
          end else begin
            scnt++;
            if (y) silent = 0;
            else begin
              silent++;
              if (silent == TMO) begin ph = 2; ne = 1'b1; end
            end
          end
        end else begin
          silent = 0;
        end
      end
      default: ph = 0;
    endcase
    m_done = nd; m_err = ne; m_rv = nrv;
  endtask

  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                         input int sm, input int wm, input int eb, input int stop_after);
    int budget;
    c_we = we; c_adr = adr; c_len = len; c_sel = 4'($urandom);
    smode = sm; wmode = wm; errbeat = eb; gap = 0;
    for (int i = 0; i < 16; i++) words[i] = (wm == 1) ? 32'(i + 1) : $urandom;
    want_cmd = 1'b1; issued = 1'b0;
    budget = 0;
    while (!(issued && ph == 0) && budget < 2000 && !(stop_after > 0 && budget >= stop_after)) begin
      cycle();
      budget++;
    end
    if (stop_after == 0) check("cmd_complete", 32'(issued && ph == 0), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    #2 wb_rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    cmd_valid = 1'b0; wdat_valid = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    repeat (2) @(negedge wb_clk);
    check_reset_outputs("rst_hold");
    #2 wb_rst_n = 1'b1;
    #1 check("rdy_before_edge", 32'(cmd_ready), 32'd0);
    ph = 0; m_done = 1'b0; m_err = 1'b0; m_rv = 1'b0;
    k = 0; wi = 0; silent = 0; scnt = 0; want_cmd = 1'b0; issued = 1'b0;
  endtask

  initial begin
    int r, sm;
    do_reset();
    // single read, ack on 2nd strobe cycle
    run_cmd(1'b0, 32'h100, 4'd0, 1, 0, 0, 0);
    // 4-beat write with a 2-cycle data gap before beat 3
    run_cmd(1'b1, 32'h200, 4'd3, 2, 1, 99, 0);
    // 8-beat read, err on beat 3
    run_cmd(1'b0, 32'h400, 4'd7, 2, 0, 2, 0);
    // single write, rty then ack
    run_cmd(1'b1, 32'h500, 4'd0, 3, 0, 0, 0);
    // address wrap-around
    run_cmd(1'b0, 32'hFFFF_FFF8, 4'd3, 2, 0, 99, 0);
    // silent slave: timeout
    run_cmd(1'b0, 32'h600, 4'd0, 4, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom % 20);
      sm = (r == 0) ? 4 : (r == 1) ? 3 : (r == 2) ? 1 : (r == 3) ? 2 : 0;
      run_cmd(1'($urandom), $urandom, 4'($urandom), sm, 0, int'($urandom % 16), 0);
    end
    // reset in the middle of a 16-beat burst
    run_cmd(1'b0, 32'h700, 4'd15, 4, 0, 0, 10);
    check("cyc_pre_rst", 32'(wb_cyc_o), 32'd1);
    do_reset();
    run_cmd(1'b1, 32'h800, 4'd2, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
